if_fetch: RTL and testbench

Instruction-fetch stage front end. Owns the program counter, issues single-outstanding requests to instruction memory, and drives the fetched instruction and its PC+4 into the IF/ID pipeline register. It absorbs hazard-unit stalls and branch/jump redirects from later stages. On a flush it inserts all-zero bubbles, which is the same value IF/ID holds out of reset.

---
 rtl/if_fetch.sv | 170 +++++++++++++++++
 tb/tb_if_fetch.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage front end feeding the IF/ID register
//
// Owns the program counter and keeps at most one instruction-memory request
// outstanding. Absorbs hazard stalls through a one-entry hold buffer and turns
// branch/jump redirects into all-zero bubbles.
//
// Optional build macro: IF_PERF_CNT_EN adds perf_fetch/perf_bubble counters.
//
// Ports:
//   clk, rst_n        pipeline clock, asynchronous active-low reset
//   stall             hold IF outputs at their current value this cycle
//   redirect_valid    flush and refetch from redirect_pc (beats stall)
//   redirect_pc       redirect target; bits [1:0] are ignored
//   imem_req/addr     fetch request and word address (stable until ack)
//   imem_ack/rdata    one-cycle response strobe and instruction word
//   IF_inst/pc4/valid IF/ID register contents; all zero for a bubble
//   perf_fetch        (IF_PERF_CNT_EN) count of valid instructions loaded
//   perf_bubble       (IF_PERF_CNT_EN) count of bubbles loaded
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_inst,
  output logic [31:0] IF_pc4,
  output logic        IF_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_bubble
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] DROP = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic [31:0] buf_inst;
  logic [31:0] buf_pc4;

  logic [31:0] req_pc4;
  logic [31:0] redir_tgt;
  logic        load_fetch;
  logic        load_buf;
  logic        load_bubble;

  // 32-bit add: 0xFFFF_FFFC wraps silently to 0
  assign req_pc4   = req_addr + 32'd4;
  assign redir_tgt = redirect_pc & ~32'h0000_0003;

  // DROP keeps the stale request on the bus until the memory answers it
  assign imem_req  = (state == REQ) || (state == DROP);
  assign imem_addr = req_addr;

  // What the output register loads this edge; none of them means "hold"
  always_comb begin
    load_fetch  = 1'b0;
    load_buf    = 1'b0;
    load_bubble = 1'b0;
    if (redirect_valid) begin
      load_bubble = 1'b1;
    end else begin
      case (state)
        REQ:     if (!stall) begin
                   if (imem_ack) load_fetch  = 1'b1;
                   else          load_bubble = 1'b1;
                 end
        HOLD:    if (!stall) load_buf = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IF_inst  <= 32'h0;
      IF_pc4   <= 32'h0;
      IF_valid <= 1'b0;
    end else if (load_bubble) begin
      IF_inst  <= 32'h0;
      IF_pc4   <= 32'h0;
      IF_valid <= 1'b0;
    end else if (load_fetch) begin
      IF_inst  <= imem_rdata;
      IF_pc4   <= req_pc4;
      IF_valid <= 1'b1;
    end else if (load_buf) begin
      IF_inst  <= buf_inst;
      IF_pc4   <= buf_pc4;
      IF_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      buf_inst <= 32'h0;
      buf_pc4  <= 32'h0;
    end else if (redirect_valid) begin
      pc       <= redir_tgt;
      buf_inst <= 32'h0;
      buf_pc4  <= 32'h0;
      // A request still in flight must be retired before the target is issued
      if (state == IDLE || state == HOLD || imem_ack) begin
        req_addr <= redir_tgt;
        state    <= REQ;
      end else begin
        state    <= DROP;
      end
    end else begin
      case (state)
        IDLE: begin
          req_addr <= pc;
          state    <= REQ;
        end
        REQ: begin
          if (imem_ack) begin
            pc <= req_pc4;
            if (stall) begin
              // Park the word; req_addr stays put until HOLD reissues from pc
              buf_inst <= imem_rdata;
              buf_pc4  <= req_pc4;
              state    <= HOLD;
            end else begin
              req_addr <= req_pc4;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            req_addr <= pc;
            state    <= REQ;
          end
        end
        default: begin
          if (imem_ack) begin
            req_addr <= pc;
            state    <= REQ;
          end
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch  <= 32'h0;
      perf_bubble <= 32'h0;
    end else begin
      if (load_fetch || load_buf) perf_fetch  <= perf_fetch + 32'd1;
      if (load_bubble)            perf_bubble <= perf_bubble + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed self-checking bench for if_fetch
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IF_inst;
  logic [31:0] IF_pc4;
  logic        IF_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_bubble;
`endif

  int checks = 0;
  int failures = 0;

  // Memory model: answers after nwait idle cycles, data = addr ^ 0xA5A5_0000
  int nwait = 0;
  int wcnt = 0;

  assign imem_ack   = imem_req && (wcnt >= nwait);
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .IF_inst        (IF_inst),
    .IF_pc4         (IF_pc4),
    .IF_valid       (IF_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch     (perf_fetch),
    .perf_bubble    (perf_bubble)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One rising edge, then sample on the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [31:0] inst,
                           input logic [31:0] pc4, input logic vld);
    check({tag, ".inst"},  IF_inst,  inst);
    check({tag, ".pc4"},   IF_pc4,   pc4);
    check({tag, ".valid"}, {31'h0, IF_valid}, {31'h0, vld});
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_out("reset", 32'h0, 32'h0, 1'b0);
    check("reset.req", {31'h0, imem_req}, 32'h0);

    // Reset release with zero-wait memory
    rst_n = 1'b1;
    step();                                     // edge 1: IDLE -> REQ
    check("e1.req",  {31'h0, imem_req}, 32'h1);
    check("e1.addr", imem_addr, 32'h0000_0100);
    check("e1.valid", {31'h0, IF_valid}, 32'h0);
    step();                                     // edge 2
    check_out("e2", 32'hA5A5_0100, 32'h0000_0104, 1'b1);
    step();
    check_out("e3", 32'hA5A5_0104, 32'h0000_0108, 1'b1);

    // Stall three cycles while 0x108 is acknowledged
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("stall", 32'hA5A5_0104, 32'h0000_0108, 1'b1);
      check("stall.req", {31'h0, imem_req}, 32'h0);
    end
    stall = 1'b0;
    step();
    check_out("unstall", 32'hA5A5_0108, 32'h0000_010C, 1'b1);
    step();
    check_out("next", 32'hA5A5_010C, 32'h0000_0110, 1'b1);

    // Two wait states; redirect arrives while 0x110 is pending
    nwait = 2;
    step();
    check_out("wait.bubble", 32'h0, 32'h0, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    step();
    redirect_valid = 1'b0;
    check_out("drop.bubble", 32'h0, 32'h0, 1'b0);
    check("drop.req",  {31'h0, imem_req}, 32'h1);
    check("drop.addr", imem_addr, 32'h0000_0110);
    step();                                     // stale ack retired
    check("drop.done.addr", imem_addr, 32'h0000_0200);
    check("drop.done.valid", {31'h0, IF_valid}, 32'h0);
    step();
    check("tgt.wait1", {31'h0, IF_valid}, 32'h0);
    step();
    check("tgt.wait2", {31'h0, IF_valid}, 32'h0);
    step();
    check_out("tgt", 32'hA5A5_0200, 32'h0000_0204, 1'b1);
    nwait = 0;

    // Redirect together with stall while in HOLD
    stall = 1'b1;
    step();
    check_out("hold", 32'hA5A5_0200, 32'h0000_0204, 1'b1);
    check("hold.req", {31'h0, imem_req}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    step();
    redirect_valid = 1'b0;
    stall = 1'b0;
    check_out("hold.redir", 32'h0, 32'h0, 1'b0);
    check("hold.redir.addr", imem_addr, 32'h0000_0300);
    step();
    check_out("hold.tgt", 32'hA5A5_0300, 32'h0000_0304, 1'b1);

    // Redirect coinciding with an ack, to the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check_out("wrap.redir", 32'h0, 32'h0, 1'b0);
    check("wrap.addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check_out("wrap", 32'h5A5A_FFFC, 32'h0000_0000, 1'b1);
    check("wrap.next", imem_addr, 32'h0000_0000);
    step();
    check_out("wrap.zero", 32'hA5A5_0000, 32'h0000_0004, 1'b1);

    // Asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    check_out("areset", 32'h0, 32'h0, 1'b0);
    check("areset.req", {31'h0, imem_req}, 32'h0);
`ifdef IF_PERF_CNT_EN
    check("areset.pf", perf_fetch, 32'h0);
    check("areset.pb", perf_bubble, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();                                     // IDLE -> REQ
    for (int i = 0; i < 5; i++) step();         // 0x100..0x110
    check_out("rs.f5", 32'hA5A5_0110, 32'h0000_0114, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();         // 0x400..0x408
    check_out("rs.f8", 32'hA5A5_0408, 32'h0000_040C, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0500;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) step();         // 0x500, 0x504
    check_out("rs.f10", 32'hA5A5_0504, 32'h0000_0508, 1'b1);
`ifdef IF_PERF_CNT_EN
    check("perf_fetch",  perf_fetch,  32'd10);
    check("perf_bubble", perf_bubble, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
